// File: rtl/obstacle_pkg.sv
// Shared screen geometry, colour codes and FSM encoding for the obstacle/floor drawers
// and the frame clock.
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] CYAN  = 3'b011;

endpackage

// File: rtl/obstacle_renderer_if.sv
// Frame-tick/status handshake plus the vga_adapter pixel-write bus of the obstacle renderer.
// The master modport is the renderer side; slave is the tick source / adapter side.
interface obstacle_renderer_if #(
    parameter int COLS = 40
) ();
    logic            start;
    logic [COLS-1:0] obstacle_data;
    logic            busy;
    logic            done;
    logic            overrun;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot;

    modport master (
        input  start, obstacle_data,
        output busy, done, overrun, x, y, colour, plot
    );

    modport slave (
        output start, obstacle_data,
        input  busy, done, overrun, x, y, colour, plot
    );
endinterface

// File: rtl/render_scan_counter.sv
// Purpose: column/pixel scan counter; pix walks one BLOCKxBLOCK tile, then col advances.
// Latency: registered counters, last decoded combinationally in the same cycle.
// Backpressure: none; advances only when step is high, clear has priority.
module render_scan_counter #(
    parameter int  COLS  = 40,
    parameter int  BLOCK = 4,
    localparam int COLW  = $clog2(COLS),
    localparam int PIXW  = 2 * $clog2(BLOCK)
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            clear,
    input  logic            step,
    output logic [COLW-1:0] col,
    output logic [PIXW-1:0] pix,
    output logic            last
);

    assign last = (col == COLW'(COLS - 1)) && (pix == '1);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn || clear) begin
            col <= '0;
            pix <= '0;
        end else if (step) begin
            if (pix == '1) begin
                pix <= '0;
                // Wrap col after the final tile so it never indexes past the snapshot.
                col <= last ? '0 : col + COLW'(1);
            end else begin
                pix <= pix + PIXW'(1);
            end
        end
    end

endmodule

// File: rtl/obstacle_renderer.sv
// Purpose: on a frame tick, snapshot the obstacle vector and write it as a strip of blocks.
// Latency: first pixel the cycle after start; COLS*BLOCK^2 plot cycles, then one done cycle.
// Backpressure: none; a start while a pass is running is dropped and flagged on overrun.
module obstacle_renderer
    import obstacle_pkg::*;
#(
    parameter int         COLS      = 40,
    parameter int         BLOCK     = 4,
    parameter int         ORIGIN_X  = 156,
    parameter int         ORIGIN_Y  = 40,
    parameter logic [2:0] FG_COLOUR = CYAN,
    parameter logic [2:0] BG_COLOUR = BLACK
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    obstacle_renderer_if.master bus
);

    localparam int LOG2B = $clog2(BLOCK);
    localparam int PIXW  = 2 * LOG2B;
    localparam int COLW  = $clog2(COLS);

    state_t            state, state_n;
    logic [COLS-1:0]   snap;
    logic [COLW-1:0]   col;
    logic [PIXW-1:0]   pix;
    logic              last;
    logic              accept;
    logic              step;
    logic [LOG2B-1:0]  px, py;

    render_scan_counter #(
        .COLS  (COLS),
        .BLOCK (BLOCK)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clear    (accept),
        .step     (step),
        .col      (col),
        .pix      (pix),
        .last     (last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
            snap  <= '0;
        end else begin
            state <= state_n;
            if (accept)
                snap <= bus.obstacle_data;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                step = 1'b1;
                if (last)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Upper half of pix is the x offset, so each block is written column-major.
    assign px = pix[PIXW-1:LOG2B];
    assign py = pix[LOG2B-1:0];

    always_comb begin
        bus.busy    = (state == DRAW);
        bus.done    = (state == DONE);
        bus.overrun = bus.start && (state != IDLE);
        bus.plot    = 1'b0;
        bus.x       = '0;
        bus.y       = '0;
        bus.colour  = '0;
        if (state == DRAW) begin
            bus.plot   = 1'b1;
            bus.x      = 8'(ORIGIN_X) + 8'(px) - (8'(col) << LOG2B);
            bus.y      = 7'(ORIGIN_Y) + 7'(py);
            bus.colour = snap[col] ? FG_COLOUR : BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_obstacle_renderer.sv
// Randomised checks of obstacle_renderer against a pixel-order and frame-image reference model.
module tb_obstacle_renderer;

    localparam int COLS  = 40;
    localparam int NPIX  = 640;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    obstacle_renderer_if #(.COLS(COLS)) bus ();

    obstacle_renderer dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int fb [160][4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pass starting from an IDLE negedge. ovr_cyc: cycle with an extra start pulse;
    // chg_cyc: cycle at which obstacle_data is cleared; rst_cyc: cycle after which reset hits.
    task automatic run_pass(input logic [39:0] data, input int ovr_cyc,
                            input int chg_cyc, input int rst_cyc);
        int nplot, nfg;
        int i, c, off, ex, ey, ec;
        logic aborted;
        nplot = 0;
        nfg   = 0;
        for (int xx = 0; xx < 160; xx++)
            for (int yy = 0; yy < 4; yy++)
                fb[xx][yy] = -1;
        bus.obstacle_data = data;
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        for (int k = 1; k <= NPIX + 2; k++) begin
            aborted = (rst_cyc > 0) && (k > rst_cyc);
            if (rst_cyc > 0 && k == rst_cyc + 1)
                resetn = 1'b1;
            if (k == chg_cyc)
                bus.obstacle_data = '0;
            bus.start = (k == ovr_cyc);
            #1;
            if (aborted || k == NPIX + 2) begin
                check("idle_busy", bus.busy, 0);
                check("idle_done", bus.done, 0);
                check("idle_plot", bus.plot, 0);
                check("idle_ovr",  bus.overrun, 0);
                check("idle_xyc",  {bus.x, bus.y, bus.colour}, 0);
            end else if (k == NPIX + 1) begin
                check("done_pulse", bus.done, 1);
                check("done_busy",  bus.busy, 0);
                check("done_plot",  bus.plot, 0);
                check("done_xyc",   {bus.x, bus.y, bus.colour}, 0);
                check("done_ovr",   bus.overrun, (k == ovr_cyc));
            end else begin
                // Pixel k-1 of the pass: tile index, then column-major offset inside the tile.
                i   = k - 1;
                c   = i / 16;
                off = i % 16;
                ex  = (156 + off / 4 - 4 * c) & 255;
                ey  = 40 + off % 4;
                ec  = data[c] ? 3 : 0;
                check("draw_busy", bus.busy, 1);
                check("draw_done", bus.done, 0);
                check("draw_plot", bus.plot, 1);
                check("draw_ovr",  bus.overrun, (k == ovr_cyc));
                check("pix_x",     bus.x, ex);
                check("pix_y",     bus.y, ey);
                check("pix_col",   bus.colour, ec);
            end
            if (bus.plot === 1'b1) begin
                nplot++;
                if (bus.colour == 3'b011) nfg++;
                check("x_range", (bus.x < 160), 1);
                if (bus.x < 160 && bus.y >= 40 && bus.y <= 43)
                    fb[bus.x][bus.y - 40] = int'(bus.colour);
            end
            if (k == rst_cyc)
                resetn = 1'b0;
            @(negedge CLOCK_50);
        end
        bus.start = 1'b0;
        if (rst_cyc < 0) begin
            check("n_plot", nplot, NPIX);
            check("n_fg",   nfg, 16 * $countones(data));
            // Frame-level view: column c covers x = 156-4c .. 159-4c across the strip.
            for (int xx = 0; xx < 160; xx++)
                for (int yy = 0; yy < 4; yy++)
                    check("image", fb[xx][yy], data[(159 - xx) / 4] ? 3 : 0);
        end else begin
            check("abort_plots", nplot, rst_cyc);
        end
    endtask

    initial begin
        logic [39:0] rd;
        bus.start = 1'b1;
        bus.obstacle_data = 40'hFF_FFFF_FFFF;
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #1;
        check("rst_busy",    bus.busy, 0);
        check("rst_done",    bus.done, 0);
        check("rst_ovr",     bus.overrun, 0);
        check("rst_plot",    bus.plot, 0);
        check("rst_xyc",     {bus.x, bus.y, bus.colour}, 0);
        bus.start = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLOCK_50);
            #1;
            check("quiet_plot", bus.plot, 0);
            check("quiet_busy", bus.busy, 0);
            check("quiet_done", bus.done, 0);
        end
        @(negedge CLOCK_50);

        run_pass(40'h1, -1, -1, -1);
        run_pass(40'h80_0000_0000, -1, -1, -1);
        run_pass(40'hAA_AAAA_AAAA, -1, 5, -1);
        run_pass({8'($urandom), 32'($urandom)}, 100, -1, -1);
        run_pass({8'($urandom), 32'($urandom)}, NPIX + 1, -1, -1);
        run_pass({8'($urandom), 32'($urandom)}, 300, -1, 300);
        run_pass({8'($urandom), 32'($urandom)}, -1, -1, -1);
        for (int r = 0; r < 4; r++) begin
            rd = {8'($urandom), 32'($urandom)};
            run_pass(rd, int'($urandom_range(1, NPIX + 1)), int'($urandom_range(2, 600)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
